fetch_decode: RTL and testbench
===============================

// Module: fetch_decode
// PURPOSE
//  Fetch/decode stage of the 16-bit core, directly upstream of the 8x16 register file.
//  - Fetches instruction words from program memory over a req/ack interface.
//  - Assembles optional immediate words.
//  - Presents decoded register indices (a/b/y), opcode and immediate to the register file and ALU.
//  - Uses a valid/ready handshake with the downstream stage.
// PARAMETERS
//  RESET_PC     16'h0000  PC value loaded on reset
//  IMM_OPCODE   4'hF      opcode whose instruction carries a trailing 16-bit immediate word
//  HALT_OPCODE  4'hE      opcode that stops fetching until reset
// PORTS
//  CLK          in   1   single clock, rising edge
//  RST_N        in   1   asynchronous, active-low reset
//  mem_req      out  1   fetch request, held until mem_ack
//  mem_addr     out  16  word address of fetch (= PC)
//  mem_ack      in   1   one-cycle pulse: mem_data valid this cycle
//  mem_data     in   16  fetched word
//  br_en        in   1   redirect from execute (one-cycle pulse)
//  br_target    in   16  redirect address
//  dec_valid    out  1   decoded instruction is available
//  dec_ready    in   1   downstream accepts it this cycle
//  dec_opcode   out  4   instr[15:12]
//  dec_yindex   out  3   instr[11:9], destination register
//  dec_aindex   out  3   instr[8:6], source A
//  dec_bindex   out  3   instr[5:3], source B
//  dec_func     out  3   instr[2:0], ALU sub-function
//  dec_imm      out  16  immediate word; 16'h0 when dec_imm_en=0
//  dec_imm_en   out  1   1 when the instruction carried an immediate
//  dec_pc       out  16  address of the first word of the instruction
//  halted       out  1   HALT_OPCODE has been accepted downstream
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - PC=RESET_PC, state=FETCH.
//  - mem_req=0, dec_valid=0, halted=0.
//  - All dec_* outputs=0.
//  - mem_req rises on the first clock after reset release.
//  FSM states FETCH, FETCH_IMM, HOLD, HALT:
//  - FETCH: mem_req=1, mem_addr=PC.
//    - On mem_ack, latch the word and PC <= PC+1.
//    - If opcode==IMM_OPCODE, go to FETCH_IMM; otherwise go to HOLD.
//  - FETCH_IMM: mem_req=1, mem_addr=PC.
//    - On mem_ack, dec_imm<=mem_data, dec_imm_en<=1, PC<=PC+1, go to HOLD.
//  - HOLD: dec_valid=1. All dec_* outputs are stable while dec_valid && !dec_ready.
//    - On dec_valid&&dec_ready: go to HALT if opcode==HALT_OPCODE, else go to FETCH.
//    - dec_valid drops the next cycle; there is no back-to-back issue, so latency is >=1 bubble per instruction.
//  - HALT: mem_req=0, dec_valid=0, halted=1. Only reset exits this state.
//  Latency: mem_ack in FETCH -> dec_valid the next cycle (single-word); two acks for IMM instructions.
//  PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000 with no flag.
//  br_en (any state except HALT) has priority over all other events in that cycle:
//  - PC<=br_target; dec_valid drops next cycle; any held instruction is discarded.
//  - If mem_req is outstanding (FETCH/FETCH_IMM), set the flush flag.
//    - The flagged request stays asserted, with unchanged mem_addr, until its mem_ack.
//    - That ack's data is dropped; the flag clears; the next cycle fetches br_target.
//  - br_en coincident with mem_ack: the data is dropped; the next fetch is from br_target.
//  - br_en coincident with dec_ready in HOLD: the instruction counts as accepted and the redirect still applies.
//  mem_addr changes only when mem_req=0 or in the cycle after mem_ack.
//  mem_ack while mem_req=0 is ignored.
// STRUCTURE
//  Shared package (core_pkg): opcode constants (IMM_OPCODE, HALT_OPCODE), field bit positions,
//  fetch-state enum, and reg-index width (3) shared with the register file.
//  One sub-module: instr_fields (combinational field slicer: word -> opcode/y/a/b/func).
//  FSM, PC and flush flag stay in fetch_decode.
// TESTING
//  1. Reset, mem_ack 1 cycle after each req, words 16'h1298, 16'h2000 -> mem_addr 0,1.
//     First decode: op=1, y=1, a=2, b=3, func=0, imm_en=0, dec_pc=0.
//  2. IMM instr: word 16'hF240 then 16'hBEEF at PC=4 -> single dec_valid.
//     Decode: op=F, y=1, a=1, imm=BEEF, imm_en=1, dec_pc=4. Next fetch address=6.
//  3. dec_ready held low 5 cycles in HOLD -> all dec_* constant, mem_req=0, no PC change.
//     Accept on cycle 6 -> fetch resumes.
//  4. br_en, br_target=16'h0100 while a fetch to 0x0010 is outstanding, ack 3 cycles later.
//     -> Acked data never appears on dec_*; next mem_addr=0x0100.
//  5. PC=16'hFFFF with IMM opcode -> immediate fetched from 16'h0000; next fetch at 16'h0001.
//  6. HALT word 16'hE000 accepted -> halted=1, mem_req stays 0 for 20 cycles.
//     RST_N pulse mid-FETCH -> mem_req=0 immediately, then restart at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode stage and the register file.
package core_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned OPC_W     = 4;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned FUNC_W    = 3;

    // Instruction field bit positions (LSB of each field)
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned Y_LSB    = 9;
    localparam int unsigned A_LSB    = 6;
    localparam int unsigned B_LSB    = 3;
    localparam int unsigned FUNC_LSB = 0;

    localparam logic [WORD_W-1:0] PC_RESET_DEF    = 16'h0000;
    localparam logic [OPC_W-1:0]  IMM_OPCODE_DEF  = 4'hF;
    localparam logic [OPC_W-1:0]  HALT_OPCODE_DEF = 4'hE;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_FETCH_IMM = 2'd1,
        ST_HOLD      = 2'd2,
        ST_HALT      = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational slicer: instruction word -> opcode / register indices / function.
module instr_fields
    import core_pkg::*;
(
    input  logic [WORD_W-1:0]    i_word,
    output logic [OPC_W-1:0]     o_opcode_c,
    output logic [REG_IDX_W-1:0] o_yindex_c,
    output logic [REG_IDX_W-1:0] o_aindex_c,
    output logic [REG_IDX_W-1:0] o_bindex_c,
    output logic [FUNC_W-1:0]    o_func_c
);

    assign o_opcode_c = i_word[OPC_LSB  +: OPC_W];
    assign o_yindex_c = i_word[Y_LSB    +: REG_IDX_W];
    assign o_aindex_c = i_word[A_LSB    +: REG_IDX_W];
    assign o_bindex_c = i_word[B_LSB    +: REG_IDX_W];
    assign o_func_c   = i_word[FUNC_LSB +: FUNC_W];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: fetches words over req/ack, assembles immediates,
// and holds one decoded instruction for the downstream valid/ready handshake.
module fetch_decode
    import core_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = PC_RESET_DEF,
    parameter logic [OPC_W-1:0]  IMM_OPCODE  = IMM_OPCODE_DEF,
    parameter logic [OPC_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
)
(
    input  logic                 CLK,
    input  logic                 RST_N,
    output logic                 mem_req,
    output logic [WORD_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_W-1:0]    mem_data,
    input  logic                 br_en,
    input  logic [WORD_W-1:0]    br_target,
    output logic                 dec_valid,
    input  logic                 dec_ready,
    output logic [OPC_W-1:0]     dec_opcode,
    output logic [REG_IDX_W-1:0] dec_yindex,
    output logic [REG_IDX_W-1:0] dec_aindex,
    output logic [REG_IDX_W-1:0] dec_bindex,
    output logic [FUNC_W-1:0]    dec_func,
    output logic [WORD_W-1:0]    dec_imm,
    output logic                 dec_imm_en,
    output logic [WORD_W-1:0]    dec_pc,
    output logic                 halted
);

    fetch_state_t r_state, w_state_nxt;

    logic [WORD_W-1:0]    r_pc, w_pc_nxt;
    logic [WORD_W-1:0]    r_addr, w_addr_nxt;
    logic                 r_req, w_req_nxt;
    logic                 r_flush, w_flush_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_halted, w_halted_nxt;
    logic                 w_ack;
    logic                 w_load_word;
    logic                 w_load_imm;

    logic [OPC_W-1:0]     r_opcode;
    logic [REG_IDX_W-1:0] r_yindex, r_aindex, r_bindex;
    logic [FUNC_W-1:0]    r_func;
    logic [WORD_W-1:0]    r_imm, r_dpc;
    logic                 r_imm_en;

    logic [OPC_W-1:0]     w_opcode;
    logic [REG_IDX_W-1:0] w_yindex, w_aindex, w_bindex;
    logic [FUNC_W-1:0]    w_func;

    instr_fields u_fields (
        .i_word     (mem_data),
        .o_opcode_c (w_opcode),
        .o_yindex_c (w_yindex),
        .o_aindex_c (w_aindex),
        .o_bindex_c (w_bindex),
        .o_func_c   (w_func)
    );

    // Next-state, PC, flush and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = r_flush;
        w_load_word = 1'b0;
        w_load_imm  = 1'b0;
        w_ack       = mem_ack && r_req;

        case (r_state)
            ST_FETCH: begin
                if (w_ack) begin
                    if (r_flush) begin
                        w_flush_nxt = 1'b0;
                    end else begin
                        w_load_word = 1'b1;
                        w_pc_nxt    = r_pc + 16'd1;
                        w_state_nxt = (w_opcode == IMM_OPCODE) ? ST_FETCH_IMM : ST_HOLD;
                    end
                end
            end
            ST_FETCH_IMM: begin
                if (w_ack) begin
                    w_load_imm  = 1'b1;
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dec_ready) begin
                    w_state_nxt = (r_opcode == HALT_OPCODE) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase

        // Redirect overrides everything; an unacked request must still drain
        if (br_en && (r_state != ST_HALT)) begin
            w_pc_nxt    = br_target;
            w_state_nxt = ST_FETCH;
            w_load_word = 1'b0;
            w_load_imm  = 1'b0;
            w_flush_nxt = r_req && !w_ack;
        end

        w_req_nxt    = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_FETCH_IMM);
        w_valid_nxt  = (w_state_nxt == ST_HOLD);
        w_halted_nxt = (w_state_nxt == ST_HALT);
        // Address is frozen while a request is outstanding
        w_addr_nxt   = (!r_req || w_ack) ? w_pc_nxt : r_addr;
    end

    // State, PC and handshake registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_addr   <= RESET_PC;
            r_req    <= 1'b0;
            r_flush  <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_addr   <= w_addr_nxt;
            r_req    <= w_req_nxt;
            r_flush  <= w_flush_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Decoded-instruction holding registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_opcode <= '0;
            r_yindex <= '0;
            r_aindex <= '0;
            r_bindex <= '0;
            r_func   <= '0;
            r_imm    <= '0;
            r_imm_en <= 1'b0;
            r_dpc    <= '0;
        end else if (w_load_word) begin
            r_opcode <= w_opcode;
            r_yindex <= w_yindex;
            r_aindex <= w_aindex;
            r_bindex <= w_bindex;
            r_func   <= w_func;
            r_imm    <= '0;
            r_imm_en <= 1'b0;
            r_dpc    <= r_addr;
        end else if (w_load_imm) begin
            r_imm    <= mem_data;
            r_imm_en <= 1'b1;
        end
    end

    assign mem_req    = r_req;
    assign mem_addr   = r_addr;
    assign dec_valid  = r_valid;
    assign halted     = r_halted;
    assign dec_opcode = r_opcode;
    assign dec_yindex = r_yindex;
    assign dec_aindex = r_aindex;
    assign dec_bindex = r_bindex;
    assign dec_func   = r_func;
    assign dec_imm    = r_imm;
    assign dec_imm_en = r_imm_en;
    assign dec_pc     = r_dpc;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: table of instructions plus redirect/stall/halt sequences.
module tb_fetch_decode;

    logic        CLK;
    logic        RST_N;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        br_en;
    logic [15:0] br_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_opcode;
    logic [2:0]  dec_yindex, dec_aindex, dec_bindex, dec_func;
    logic [15:0] dec_imm;
    logic        dec_imm_en;
    logic [15:0] dec_pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] word;
        logic        has_imm;
        logic [15:0] imm;
        logic [3:0]  op;
        logic [2:0]  y, a, b, f;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[6];

    fetch_decode dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .br_en      (br_en),
        .br_target  (br_target),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_opcode (dec_opcode),
        .dec_yindex (dec_yindex),
        .dec_aindex (dec_aindex),
        .dec_bindex (dec_bindex),
        .dec_func   (dec_func),
        .dec_imm    (dec_imm),
        .dec_imm_en (dec_imm_en),
        .dec_pc     (dec_pc),
        .halted     (halted)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for a request, idle 'delay' cycles, then ack with data
    task automatic serve(input logic [15:0] data, input int delay, output logic [15:0] addr);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(mem_req), 32'd1);
        repeat (delay) tick();
        addr     = mem_addr;
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
        mem_data = 16'h0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!dec_valid && n < 50) begin
            tick();
            n++;
        end
        chk("valid_seen", 32'(dec_valid), 32'd1);
    endtask

    task automatic accept();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input vec_t v);
        chk({tag, "_op"},     32'(dec_opcode), 32'(v.op));
        chk({tag, "_y"},      32'(dec_yindex), 32'(v.y));
        chk({tag, "_a"},      32'(dec_aindex), 32'(v.a));
        chk({tag, "_b"},      32'(dec_bindex), 32'(v.b));
        chk({tag, "_func"},   32'(dec_func),   32'(v.f));
        chk({tag, "_imm"},    32'(dec_imm),    v.has_imm ? 32'(v.imm) : 32'd0);
        chk({tag, "_imm_en"}, 32'(dec_imm_en), 32'(v.has_imm));
        chk({tag, "_pc"},     32'(dec_pc),     32'(v.pc));
    endtask

    initial begin
        logic [15:0] a;
        vec_t        v;
        int          bad;
        logic [3:0]  s_op;
        logic [15:0] s_pc;

        vecs[0] = '{16'h1298, 1'b0, 16'h0000, 4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 16'h0000};
        vecs[1] = '{16'h2000, 1'b0, 16'h0000, 4'h2, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0001};
        vecs[2] = '{16'h3A5F, 1'b0, 16'h0000, 4'h3, 3'd5, 3'd1, 3'd3, 3'd7, 16'h0002};
        vecs[3] = '{16'h7FFF, 1'b0, 16'h0000, 4'h7, 3'd7, 3'd7, 3'd7, 3'd7, 16'h0003};
        vecs[4] = '{16'hF240, 1'b1, 16'hBEEF, 4'hF, 3'd1, 3'd1, 3'd0, 3'd0, 16'h0004};
        vecs[5] = '{16'h4123, 1'b0, 16'h0000, 4'h4, 3'd0, 3'd4, 3'd4, 3'd3, 16'h0006};

        RST_N = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
        br_en = 1'b0; br_target = 16'h0; dec_ready = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        chk("rst_req",    32'(mem_req),    32'd0);
        chk("rst_valid",  32'(dec_valid),  32'd0);
        chk("rst_halted", 32'(halted),     32'd0);
        chk("rst_addr",   32'(mem_addr),   32'd0);
        chk("rst_op",     32'(dec_opcode), 32'd0);
        chk("rst_pc",     32'(dec_pc),     32'd0);
        tick();
        chk("first_req", 32'(mem_req), 32'd1);

        // Table of straight-line instructions
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            serve(v.word, 1, a);
            chk("word_addr", 32'(a), 32'(v.pc));
            if (v.has_imm) begin
                chk("imm_gap_valid", 32'(dec_valid), 32'd0);
                serve(v.imm, 0, a);
                chk("imm_addr", 32'(a), 32'(v.pc + 16'd1));
            end
            wait_valid();
            chk_dec($sformatf("vec%0d", i), v);
            accept();
            chk("drop_valid", 32'(dec_valid), 32'd0);
            chk("next_addr",  32'(mem_addr),  32'(v.pc + (v.has_imm ? 16'd2 : 16'd1)));
        end

        // Stall in HOLD for 5 cycles
        serve(16'h5555, 0, a);
        chk("stall_addr", 32'(a), 32'h7);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!dec_valid || mem_req || mem_addr != 16'h8 || dec_opcode != 4'h5 ||
                dec_yindex != 3'd2 || dec_aindex != 3'd5 || dec_bindex != 3'd2 ||
                dec_func != 3'd5 || dec_pc != 16'h7) bad++;
        end
        chk("stall_stable", 32'(bad), 32'd0);
        accept();
        chk("stall_resume_req",  32'(mem_req),  32'd1);
        chk("stall_resume_addr", 32'(mem_addr), 32'h8);

        // Redirect coincident with ack: data dropped
        mem_ack = 1'b1; mem_data = 16'h6666; br_en = 1'b1; br_target = 16'h0010;
        tick();
        mem_ack = 1'b0; br_en = 1'b0;
        chk("brack_addr",  32'(mem_addr),  32'h10);
        chk("brack_req",   32'(mem_req),   32'd1);
        chk("brack_valid", 32'(dec_valid), 32'd0);

        // Redirect with request outstanding: address frozen until its ack
        br_en = 1'b1; br_target = 16'h0100;
        tick();
        br_en = 1'b0;
        bad = 0;
        for (int c = 0; c < 2; c++) begin
            if (mem_addr != 16'h10 || !mem_req) bad++;
            tick();
        end
        chk("flush_hold", 32'(bad), 32'd0);
        mem_ack = 1'b1; mem_data = 16'h7777;
        tick();
        mem_ack = 1'b0;
        chk("flush_addr",  32'(mem_addr),  32'h100);
        chk("flush_valid", 32'(dec_valid), 32'd0);
        serve(16'h1111, 0, a);
        chk("tgt_addr", 32'(a), 32'h100);
        wait_valid();
        chk_dec("tgt", '{16'h1111, 1'b0, 16'h0, 4'h1, 3'd0, 3'd4, 3'd2, 3'd1, 16'h0100});

        // Redirect coincident with accept, to the top of memory
        dec_ready = 1'b1; br_en = 1'b1; br_target = 16'hFFFF;
        tick();
        dec_ready = 1'b0; br_en = 1'b0;
        chk("bracc_valid", 32'(dec_valid), 32'd0);
        chk("bracc_addr",  32'(mem_addr),  32'hFFFF);
        chk("bracc_req",   32'(mem_req),   32'd1);

        // Immediate instruction straddling PC wrap
        serve(16'hF123, 0, a);
        chk("wrap_addr0", 32'(a), 32'hFFFF);
        serve(16'h1234, 0, a);
        chk("wrap_addr1", 32'(a), 32'h0000);
        wait_valid();
        chk_dec("wrap", '{16'hF123, 1'b1, 16'h1234, 4'hF, 3'd0, 3'd4, 3'd4, 3'd3, 16'hFFFF});
        accept();
        chk("wrap_next", 32'(mem_addr), 32'h0001);

        // HALT accepted: no more fetches, redirects and acks ignored
        serve(16'hE000, 0, a);
        wait_valid();
        chk("halt_op", 32'(dec_opcode), 32'hE);
        chk("halt_pre", 32'(halted), 32'd0);
        accept();
        chk("halted", 32'(halted), 32'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ack   = (c % 3 == 0);
            br_en     = (c == 7);
            br_target = 16'h0400;
            tick();
            if (mem_req || dec_valid || !halted) bad++;
        end
        mem_ack = 1'b0; br_en = 1'b0;
        chk("halt_quiet", 32'(bad), 32'd0);
        chk("halt_addr",  32'(mem_addr), 32'h0002);

        // Reset exits HALT
        RST_N = 1'b0;
        #1;
        chk("rst2_halted", 32'(halted),  32'd0);
        chk("rst2_req",    32'(mem_req), 32'd0);
        #2 RST_N = 1'b1;
        tick();
        chk("rst2_req_up", 32'(mem_req),  32'd1);
        chk("rst2_addr",   32'(mem_addr), 32'h0);

        // Async reset mid-FETCH
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_req",   32'(mem_req),    32'd0);
        chk("midrst_addr",  32'(mem_addr),   32'h0);
        chk("midrst_valid", 32'(dec_valid),  32'd0);
        chk("midrst_op",    32'(dec_opcode), 32'd0);
        RST_N = 1'b1;
        tick();
        chk("midrst_restart", 32'(mem_req), 32'd1);
        serve(16'h2000, 0, a);
        chk("restart_addr", 32'(a), 32'h0);
        wait_valid();
        s_op = dec_opcode;
        s_pc = dec_pc;
        chk("restart_op", 32'(s_op), 32'h2);
        chk("restart_pc", 32'(s_pc), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
